// File: rtl/uart_pkg.sv
// Shared constants and types for the UART bus controller:
// register selects, status bit positions and the TX sequencer states.
package uart_pkg;

    localparam logic SEL_DATA   = 1'b0;
    localparam logic SEL_STATUS = 1'b1;

    localparam int ST_TX_OK    = 0;
    localparam int ST_RX_AVAIL = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_TX_OVR   = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push is accepted when
// full as long as a pop frees the head slot in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-facing UART controller: TX/RX byte FIFOs, sticky overrun flags
// and a sequencer driving the transmitter start/busy handshake.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        irq
);

    logic       w_data_rd;
    logic       w_stat_rd;
    logic       w_data_wr;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;
    logic       w_tx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;
    logic       w_rx_pop;
    logic       w_rx_drop;
    logic       w_tx_drop;
    logic [15:0] w_status;

    logic       r_rx_ovr;
    logic       r_tx_ovr;

    tx_state_t  r_state;
    tx_state_t  w_next;
    logic       r_wait_cnt;
    logic       w_wait_nxt;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    assign w_data_rd = bus_rd && (bus_sel == SEL_DATA);
    assign w_stat_rd = bus_rd && (bus_sel == SEL_STATUS);
    assign w_data_wr = bus_wr && (bus_sel == SEL_DATA);

    assign w_rx_pop  = w_data_rd && !w_rx_empty;
    assign w_rx_drop = rx_ready && w_rx_full && !w_rx_pop;
    assign w_tx_drop = w_data_wr && w_tx_full && !w_tx_pop;

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_data_wr),
        .i_wdata (bus_wdata),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_ready),
        .i_wdata (rx_data),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    // A set event in the same cycle as a STATUS read keeps the flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ovr <= 1'b0;
            r_tx_ovr <= 1'b0;
        end else begin
            if (w_rx_drop)      r_rx_ovr <= 1'b1;
            else if (w_stat_rd) r_rx_ovr <= 1'b0;
            if (w_tx_drop)      r_tx_ovr <= 1'b1;
            else if (w_stat_rd) r_tx_ovr <= 1'b0;
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_OK]    = !w_tx_full;
        w_status[ST_RX_AVAIL] = !w_rx_empty;
        w_status[ST_RX_OVR]   = r_rx_ovr;
        w_status[ST_TX_OVR]   = r_tx_ovr;
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_rd) begin
            if (bus_sel == SEL_STATUS) bus_rdata = w_status;
            else if (!w_rx_empty)      bus_rdata = {8'h00, w_rx_head};
        end
    end

    assign irq = !w_rx_empty;

    // WAIT_BUSY gives up after two cycles in case busy never shows
    always_comb begin
        w_next     = r_state;
        w_tx_pop   = 1'b0;
        w_wait_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_tx_empty && !tx_busy) begin
                    w_next   = LAUNCH;
                    w_tx_pop = 1'b1;
                end
            end
            LAUNCH: w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy || r_wait_cnt) w_next = WAIT_DONE;
                else                       w_wait_nxt = 1'b1;
            end
            WAIT_DONE: begin
                if (!tx_busy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            r_tx_start <= (w_next == LAUNCH);
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based model with a transmitter stand-in,
// directed scenarios with literal expectations, then random traffic.
module tb_uart_ctrl;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_sel = 1'b0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_wdata = 8'h00;
    logic [15:0] bus_rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        irq;

    always #5 clk = ~clk;

    uart_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_sel   (bus_sel),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [15:0] act,
                                  logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] launched[$];
    bit         m_rx_ovr;
    bit         m_tx_ovr;
    logic [7:0] m_tx_data;
    int         cyc = 0;
    int         last_launch = -100;
    int         stall = 0;
    bit         prev_start = 1'b0;

    // Inputs as seen by the DUT at the coming edge
    bit         s_rst = 1'b1;
    bit         s_rd, s_wr, s_sel, s_rxr, s_busy;
    logic [7:0] s_wd, s_rxd;

    // Transmitter stand-in
    int         busy_len = 10;
    bit         force_busy = 1'b0;
    bit         rand_len = 1'b0;
    bit         pend = 1'b0;
    int         bcnt = 0;

    function automatic logic [15:0] exp_status();
        return {12'h000, m_tx_ovr, m_rx_ovr,
                rxq.size() != 0, txq.size() != TXD};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || s_rst) begin
                txq.delete();
                rxq.delete();
                m_rx_ovr = 1'b0;
                m_tx_ovr = 1'b0;
                m_tx_data = 8'h00;
                last_launch = cyc - 100;
                stall = 0;
                check("rst_tx_start", tx_start, 1'b0);
            end else begin
                bit launch, rxset, txset, ok;
                launch = tx_start && !prev_start;
                rxset = 1'b0;
                txset = 1'b0;
                if (prev_start) check("start_width", tx_start, 1'b0);
                if (launch) begin
                    check("launch_nonempty", txq.size() != 0, 1'b1);
                    check("launch_busy", s_busy, 1'b0);
                    ok = (cyc - last_launch) >= 4;
                    check("launch_gap", ok, 1'b1);
                    if (txq.size() != 0) begin
                        m_tx_data = txq.pop_front();
                        launched.push_back(m_tx_data);
                    end
                    last_launch = cyc;
                end
                if (s_wr && !s_sel) begin
                    if (txq.size() < TXD) txq.push_back(s_wd);
                    else txset = 1'b1;
                end
                if (s_rd && !s_sel && rxq.size() != 0)
                    void'(rxq.pop_front());
                if (s_rxr) begin
                    if (rxq.size() < RXD) rxq.push_back(s_rxd);
                    else rxset = 1'b1;
                end
                if (rxset) m_rx_ovr = 1'b1;
                else if (s_rd && s_sel) m_rx_ovr = 1'b0;
                if (txset) m_tx_ovr = 1'b1;
                else if (s_rd && s_sel) m_tx_ovr = 1'b0;
                if (!launch && txq.size() != 0 && !s_busy) begin
                    stall++;
                    ok = stall <= 8;
                    check("tx_stall", ok, 1'b1);
                end else begin
                    stall = 0;
                end
            end
            prev_start = tx_start;

            check("irq", irq, rxq.size() != 0);
            check("tx_data", tx_data, m_tx_data);
            if (bus_rd && bus_sel)
                check("rdata_status", bus_rdata, exp_status());
            else if (bus_rd)
                check("rdata_data", bus_rdata,
                      rxq.size() != 0 ? {8'h00, rxq[0]} : 16'h0000);
            else
                check("rdata_idle", bus_rdata, 16'h0000);

            if (pend) begin
                if (rand_len) busy_len = int'($urandom_range(0, 3)) * 4;
                bcnt = busy_len;
                pend = 1'b0;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            if (tx_start) pend = 1'b1;
            tx_busy = force_busy || (bcnt > 0);

            s_rst  = rst;
            s_rd   = bus_rd;
            s_wr   = bus_wr;
            s_sel  = bus_sel;
            s_wd   = bus_wdata;
            s_rxr  = rx_ready;
            s_rxd  = rx_data;
            s_busy = tx_busy;
        end
    end

    task automatic drive(input bit rd, input bit wr, input bit sel,
                         input logic [7:0] wd, input bit rxr,
                         input logic [7:0] rxd);
        @(posedge clk);
        #2;
        bus_rd = rd;
        bus_wr = wr;
        bus_sel = sel;
        bus_wdata = wd;
        rx_ready = rxr;
        rx_data = rxd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        drive(0, 1, 0, b, 0, 8'h00);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        drive(0, 0, 0, 8'h00, 1, b);
    endtask

    task automatic rd_chk(input bit sel, input logic [15:0] exp,
                          input string name);
        drive(1, 0, sel, 8'h00, 0, 8'h00);
        @(negedge clk);
        #1;
        check(name, bus_rdata, exp);
    endtask

    int n0;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_irq", irq, 1'b0);
        check("rst_start", tx_start, 1'b0);
        check("rst_txdata", tx_data, 8'h00);
        rd_chk(1, 16'h0001, "status_reset");
        rd_chk(0, 16'h0000, "data_reset");

        busy_len = 10;
        n0 = launched.size();
        wr_byte(8'h41);
        wr_byte(8'h42);
        idle(40);
        check("t2_count", 16'(launched.size() - n0), 16'd2);
        check("t2_b0", launched[n0], 8'h41);
        check("t2_b1", launched[n0 + 1], 8'h42);

        force_busy = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) wr_byte(8'h50 + 8'(i));
        rd_chk(1, 16'h0000, "t3_full");
        wr_byte(8'h54);
        rd_chk(1, 16'h0008, "t3_ovr");
        rd_chk(1, 16'h0000, "t3_ovr_clr");
        n0 = launched.size();
        force_busy = 1'b0;
        busy_len = 3;
        idle(60);
        check("t3_count", 16'(launched.size() - n0), 16'd4);
        for (int i = 0; i < 4; i++)
            check("t3_order", launched[n0 + i], 8'h50 + 8'(i));

        for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i));
        idle(1);
        check("t4_irq", irq, 1'b1);
        for (int i = 0; i < 4; i++)
            rd_chk(0, 16'h0010 + 16'(i), "t4_read");
        rd_chk(0, 16'h0000, "t4_empty");
        rd_chk(1, 16'h0005, "t4_status");
        rd_chk(1, 16'h0001, "t4_status_clr");

        for (int i = 0; i < 4; i++) rx_byte(8'h20 + 8'(i));
        drive(1, 0, 0, 8'h00, 1, 8'h55);
        @(negedge clk);
        #1;
        check("t5_read", bus_rdata, 16'h0020);
        rd_chk(1, 16'h0003, "t5_status");
        rd_chk(0, 16'h0021, "t5_r1");
        rd_chk(0, 16'h0022, "t5_r2");
        rd_chk(0, 16'h0023, "t5_r3");
        rd_chk(0, 16'h0055, "t5_r4");
        rd_chk(1, 16'h0001, "t5_final");

        busy_len = 30;
        n0 = launched.size();
        wr_byte(8'h77);
        wr_byte(8'h78);
        idle(6);
        check("t6_first", 16'(launched.size() - n0), 16'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rd_chk(1, 16'h0001, "t6_status");
        wr_byte(8'h79);
        idle(3);
        check("t6_hold", 16'(launched.size() - n0), 16'd1);
        idle(40);
        check("t6_count", 16'(launched.size() - n0), 16'd2);
        check("t6_byte", launched[n0 + 1], 8'h79);

        rand_len = 1'b1;
        repeat (2000) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(0, 4) == 0, 8'($urandom));
        end
        idle(80);
        rd_chk(1, 16'h0001 | {14'h0, rxq.size() != 0, 1'b1} |
               {12'h0, m_tx_ovr, m_rx_ovr, 2'b00}, "rand_status");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Memory-mapped controller that sits between the CPU data bus and the async_transmitter/async_receiver pair, and sequences both.
- Buffers outgoing bytes in a TX FIFO and launches them one at a time on the transmitter's start/busy handshake.
- Captures every receiver ready pulse into an RX FIFO.
- Exposes a data register and a status register to software.

Parameters:
TX_DEPTH, 4, TX FIFO entries; power of 2, >=2
RX_DEPTH, 4, RX FIFO entries; power of 2, >=2

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  asynchronous, active-high reset
bus_sel  in  1  register select: 0=DATA, 1=STATUS
bus_rd  in  1  read strobe, one cycle per access
bus_wr  in  1  write strobe, one cycle per access
bus_wdata  in  8  write data (DATA register only)
bus_rdata  out  16  read data, combinational from bus_sel/bus_rd
tx_start  out  1  to transmitter: launch pulse
tx_data  out  8  to transmitter: byte to send
tx_busy  in  1  from transmitter
rx_ready  in  1  from receiver: one-cycle byte-valid pulse
rx_data  in  8  from receiver: received byte
irq  out  1  level interrupt: rx_avail

Behaviour:
- Reset (async): both FIFOs empty, TX FSM = IDLE, tx_start=0, tx_data=0, sticky flags=0. As a consequence, irq=0 and bus_rdata=0.
- STATUS word, zero-extended to 16 bits:
  - bit0 tx_ok = TX FIFO not full
  - bit1 rx_avail = RX FIFO not empty
  - bit2 rx_ovr (sticky)
  - bit3 tx_ovr (sticky)
- STATUS read: returns the current flags. rx_ovr and tx_ovr clear at the end of that cycle. A set event in the same cycle wins, so the flag stays 1.
- DATA read:
  - RX FIFO not empty: bus_rdata = {8'h00, head}; head pops at the clock edge.
  - RX FIFO empty: returns 0, no pop.
- DATA write:
  - TX FIFO not full: push bus_wdata.
  - TX FIFO full: byte dropped, tx_ovr set.
- STATUS write: ignored.
- bus_rd and bus_wr asserted together: both take effect.
- RX capture: rx_ready pushes rx_data.
  - RX FIFO full and no pop in that cycle: byte dropped, rx_ovr set.
  - RX FIFO full with a DATA read pop in the same cycle: push and pop both occur, no overrun.
- TX FIFO push and pop in the same cycle is allowed at any occupancy, including full.
- TX FSM (tx_start is registered, high only in LAUNCH):
  - IDLE: if TX FIFO not empty and tx_busy=0 -> LAUNCH. tx_data <= head; pop head.
  - LAUNCH: tx_start=1 for exactly one cycle -> WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 -> WAIT_DONE. Also exit to WAIT_DONE after 2 cycles if busy was never seen (transmitter's 1-cycle start latency guard).
  - WAIT_DONE: on tx_busy=0 -> IDLE.
- Back-to-back bytes: minimum 4 controller cycles between successive tx_start pulses, plus the transmitter's frame time.
- tx_data holds its value from LAUNCH until the next LAUNCH.
- Reset mid-frame: the transmitter is not reset. The IDLE guard on tx_busy=0 guarantees no launch until the frame in flight completes.
- irq = rx_avail, registered-free.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. full = pointers differ only in MSB; empty = pointers equal.

Decomposition:
- Package uart_pkg: SEL_DATA/SEL_STATUS constants, status bit indices (ST_TX_OK=0, ST_RX_AVAIL=1, ST_RX_OVR=2, ST_TX_OVR=3), TX FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- Sub-module uart_fifo (parameterised DEPTH/WIDTH, push/pop/full/empty/head), instantiated twice.

Test Plan:
- Reset, then STATUS read -> 16'h0001. irq=0, tx_start=0.
- Write 8'h41, 8'h42 with tx_busy modelled as 10 cycles high starting 1 cycle after tx_start -> two tx_start pulses with tx_data 8'h41 then 8'h42. Second pulse no earlier than 1 cycle after busy falls.
- Write 5 bytes with tx_busy held high -> status bit0=0 after the 4th write, 5th byte dropped, tx_ovr=1. STATUS read returns 16'h0008 (bit3 set); the following STATUS read returns 16'h0000 (tx_ok still 0 until a byte drains).
- rx_ready pulses with 8'h10..8'h14, no reads -> irq=1. The first 4 bytes are read back in order; 8'h14 is dropped and rx_ovr=1. DATA read when empty -> 16'h0000.
- RX FIFO full, rx_ready with 8'h55 in the same cycle as a DATA read -> read returns the oldest byte, 8'h55 is enqueued, rx_ovr stays 0.
- Assert rst during WAIT_DONE while tx_busy=1, with the TX FIFO non-empty -> FIFO cleared, no tx_start. A write after reset launches only once tx_busy=0.
